// File: rtl/nanorv32_test_status_pkg.sv
// nanorv32 test-status responder: register offsets, magic words, result codes.
// Shared by the RTL, the benches and firmware-facing code.
package nanorv32_test_status_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_WDOG   = 2'd1;
  localparam logic [1:0] REG_CYCLES = 2'd2;
  localparam logic [1:0] REG_CHAR   = 2'd3;

  localparam logic [31:0] MAGIC_PASS = 32'hCAFFE000;
  localparam logic [31:0] MAGIC_FAIL = 32'hDEAD0000;

  localparam logic [1:0] RES_PASS    = 2'd0;
  localparam logic [1:0] RES_FAIL    = 2'd1;
  localparam logic [1:0] RES_UNKNOWN = 2'd2;
  localparam logic [1:0] RES_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_UNKNOWN,
    ST_TIMEOUT
  } tstat_state_e;

endpackage

// File: rtl/nanorv32_test_status_fifo.sv
// nanorv32_tstat_fifo: synchronous character FIFO, power-of-two depth.
// Head is visible on dout; dout reads 0 while empty.
module nanorv32_tstat_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/nanorv32_test_status.sv
// nanorv32 test-status responder: sticky done/result, cycle counter, char FIFO.
// Watchdog present only when NANORV32_TSTAT_WDOG_EN is defined.
module nanorv32_test_status
  import nanorv32_test_status_pkg::*;
#(
  parameter logic [31:0] WDOG_RESET      = 32'd1000000,
  parameter int          CHAR_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        wr,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        done,
  output logic [1:0]  result,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready
);

  tstat_state_e state_q;
  tstat_state_e state_d;
  logic [1:0]   reg_sel;
  logic         fifo_full;
  logic         fifo_empty;
  logic         acc_wr;
  logic         acc_rd;
  logic         st_wr;
  logic         push;
  logic         expire;
  logic [31:0]  cyc_q;
  logic [31:0]  wdog_rd;
  logic [31:0]  rd_mux;
  logic         unused_addr;

  assign reg_sel     = addr[3:2];
  assign unused_addr = ^addr[1:0];
  assign ready  = sel & ~(wr & (reg_sel == REG_CHAR) & fifo_full);
  assign acc_wr = ready & wr;
  assign acc_rd = ready & ~wr;
  assign st_wr  = acc_wr & (reg_sel == REG_STATUS);
  assign push   = acc_wr & (reg_sel == REG_CHAR);
  assign done   = (state_q != ST_RUN);

`ifdef NANORV32_TSTAT_WDOG_EN
  logic [31:0] wdog_q;
  logic        wdog_wr;

  assign wdog_wr = acc_wr & (reg_sel == REG_WDOG);
  // reload beats expiry, so a same-cycle reload never times out
  assign expire  = (state_q == ST_RUN) & ~wdog_wr &
                   (wdog_q == 32'd1);
  assign wdog_rd = wdog_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= WDOG_RESET;
    end else if (wdog_wr) begin
      wdog_q <= wdata;
    end else if (state_q == ST_RUN && wdog_q != 32'd0) begin
      wdog_q <= wdog_q - 32'd1;
    end
  end
`else
  logic unused_wdog;

  assign unused_wdog = ^WDOG_RESET;
  assign expire      = 1'b0;
  assign wdog_rd     = 32'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (st_wr) begin
        unique case (1'b1)
          (wdata == MAGIC_PASS): state_d = ST_PASS;
          (wdata == MAGIC_FAIL): state_d = ST_FAIL;
          default:               state_d = ST_UNKNOWN;
        endcase
      end else if (expire) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  always_comb begin
    result = RES_PASS;
    unique case (state_q)
      ST_FAIL:    result = RES_FAIL;
      ST_UNKNOWN: result = RES_UNKNOWN;
      ST_TIMEOUT: result = RES_TIMEOUT;
      default:    result = RES_PASS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cyc_q <= 32'd0;
    else if (!done) cyc_q <= cyc_q + 32'd1;
  end

  always_comb begin
    rd_mux = 32'd0;
    unique case (reg_sel)
      REG_STATUS: rd_mux = {28'd0, done, 1'b0, result};
      REG_WDOG:   rd_mux = wdog_rd;
      REG_CYCLES: rd_mux = cyc_q;
      REG_CHAR:   rd_mux = {30'd0, fifo_full, fifo_empty};
      default:    rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rdata <= 32'd0;
    else if (acc_rd) rdata <= rd_mux;
  end

  nanorv32_tstat_fifo #(
    .DEPTH (CHAR_FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (char_ready),
    .din   (wdata[7:0]),
    .dout  (char_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign char_valid = ~fifo_empty;

endmodule

// File: tb/tb_nanorv32_test_status.sv
// Bench for nanorv32_test_status: directed cases plus random traffic
// checked against a queue-based behavioural model.
module tb_nanorv32_test_status;
  import nanorv32_test_status_pkg::*;

  localparam logic [31:0] WDR   = 32'd200;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic        done;
  logic [1:0]  result;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  logic        m_done;
  logic [1:0]  m_res;
  logic [31:0] m_cyc;
  logic [31:0] m_wd;
  logic [31:0] m_rdata;
  byte unsigned q[$];
  byte unsigned pop_log[$];

  always #5 clk = ~clk;

  nanorv32_test_status #(
    .WDOG_RESET      (WDR),
    .CHAR_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .wr         (wr),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .done       (done),
    .result     (result),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_done  = 1'b0;
    m_res   = 2'd0;
    m_cyc   = 32'd0;
`ifdef NANORV32_TSTAT_WDOG_EN
    m_wd    = WDR;
`else
    m_wd    = 32'd0;
`endif
    m_rdata = 32'd0;
    q.delete();
  endtask

  task automatic check_outputs();
    chk("done", 32'(done), 32'(m_done));
    chk("result", 32'(result), 32'(m_res));
    chk("char_valid", 32'(char_valid), 32'(q.size() != 0));
    chk("char_data", 32'(char_data),
        (q.size() != 0) ? 32'(q[0]) : 32'd0);
    chk("rdata", rdata, m_rdata);
  endtask

  // Drive one bus cycle from a negedge, update the model, check after the edge.
  task automatic cycle(input logic s, input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic cr,
                       output logic acc);
    logic exp_rdy;
    logic popped;
    logic pre_done;
    logic st_hit;
    sel = s; wr = w; addr = a; wdata = d; char_ready = cr;
    #1;
    exp_rdy = s && !(w && a[3:2] == REG_CHAR && q.size() == DEPTH);
    chk("ready", 32'(ready), 32'(exp_rdy));
    acc = exp_rdy;
    if (cr && char_valid) pop_log.push_back(char_data);
    pre_done = m_done;
    st_hit = 1'b0;
    if (exp_rdy && !w) begin
      case (a[3:2])
        REG_STATUS: m_rdata = {28'd0, m_done, 1'b0, m_res};
        REG_WDOG:   m_rdata = m_wd;
        REG_CYCLES: m_rdata = m_cyc;
        default:    m_rdata = {30'd0, q.size() == DEPTH, q.size() == 0};
      endcase
    end
    popped = cr && (q.size() > 0);
    if (exp_rdy && w && a[3:2] == REG_CHAR) q.push_back(d[7:0]);
    if (popped) void'(q.pop_front());
    if (!pre_done && exp_rdy && w && a[3:2] == REG_STATUS) begin
      m_done = 1'b1;
      m_res  = (d == 32'hCAFFE000) ? 2'd0 :
               (d == 32'hDEAD0000) ? 2'd1 : 2'd2;
      st_hit = 1'b1;
    end
`ifdef NANORV32_TSTAT_WDOG_EN
    if (exp_rdy && w && a[3:2] == REG_WDOG) begin
      m_wd = d;
    end else if (!pre_done) begin
      if (m_wd == 32'd1 && !st_hit) begin
        m_done = 1'b1;
        m_res  = 2'd3;
      end
      if (m_wd != 32'd0) m_wd = m_wd - 32'd1;
    end
`endif
    if (!pre_done) m_cyc = m_cyc + 32'd1;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic cr);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 32'd0, cr, acc);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d,
                        input logic cr);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      cycle(1'b1, 1'b1, a, d, cr, acc);
      n++;
    end
    if (!acc) chk("write_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_reg(input logic [3:0] a);
    logic acc;
    cycle(1'b1, 1'b0, a, 32'd0, 1'b0, acc);
  endtask

  task automatic do_reset();
    sel = 1'b0; wr = 1'b0; addr = 4'd0; wdata = 32'd0; char_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_char_valid", 32'(char_valid), 32'd0);
    chk("rst_char_data", 32'(char_data), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic        acc;
    logic        s;
    logic        w;
    logic        cr;
    int          k;
    logic [1:0]  k2;
    logic [31:0] d;
    byte unsigned exp_chars[5];

    model_reset();
    @(negedge clk);
    do_reset();

    // PASS at cycle 20, sticky against later writes
    idle(19, 1'b0);
    wr_reg({REG_STATUS, 2'b00}, MAGIC_PASS, 1'b0);
    chk("pass_done", 32'(done), 32'd1);
    chk("pass_result", 32'(result), 32'd0);
    rd_reg({REG_CYCLES, 2'b00});
    chk("cycles_at_pass", rdata, 32'd20);
    wr_reg({REG_STATUS, 2'b00}, MAGIC_FAIL, 1'b0);
    chk("pass_sticky", 32'(result), 32'd0);
    rd_reg({REG_STATUS, 2'b00});
    chk("status_read", rdata, 32'h0000_0008);

    do_reset();
    wr_reg({REG_STATUS, 2'b00}, MAGIC_FAIL, 1'b0);
    chk("fail_result", 32'(result), 32'd1);
    do_reset();
    wr_reg({REG_STATUS, 2'b00}, 32'h12345678, 1'b0);
    chk("unknown_result", 32'(result), 32'd2);

    // watchdog
    do_reset();
`ifdef NANORV32_TSTAT_WDOG_EN
    wr_reg({REG_WDOG, 2'b00}, 32'd5, 1'b0);
    idle(4, 1'b0);
    chk("wdog_not_yet", 32'(done), 32'd0);
    idle(1, 1'b0);
    chk("wdog_done", 32'(done), 32'd1);
    chk("wdog_result", 32'(result), 32'd3);
    do_reset();
    wr_reg({REG_WDOG, 2'b00}, 32'd5, 1'b0);
    wr_reg({REG_WDOG, 2'b00}, 32'd0, 1'b0);
    idle(12, 1'b0);
    chk("wdog_disarm", 32'(done), 32'd0);
    do_reset();
    wr_reg({REG_WDOG, 2'b00}, 32'd3, 1'b0);
    idle(2, 1'b0);
    wr_reg({REG_STATUS, 2'b00}, MAGIC_PASS, 1'b0);
    chk("race_done", 32'(done), 32'd1);
    chk("race_result", 32'(result), 32'd0);
`else
    wr_reg({REG_WDOG, 2'b00}, 32'd5, 1'b0);
    idle(12, 1'b0);
    chk("nowdog_done", 32'(done), 32'd0);
    rd_reg({REG_WDOG, 2'b00});
    chk("nowdog_read", rdata, 32'd0);
`endif

    // FIFO back-pressure and ordering
    do_reset();
    exp_chars = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    for (int i = 0; i < 4; i++)
      wr_reg({REG_CHAR, 2'b00}, 32'(exp_chars[i]), 1'b0);
    pop_log.delete();
    cycle(1'b1, 1'b1, {REG_CHAR, 2'b00}, 32'h45, 1'b0, acc);
    chk("push5_stall", 32'(acc), 32'd0);
    cycle(1'b1, 1'b1, {REG_CHAR, 2'b00}, 32'h45, 1'b1, acc);
    chk("push5_stall_pop", 32'(acc), 32'd0);
    cycle(1'b1, 1'b1, {REG_CHAR, 2'b00}, 32'h45, 1'b1, acc);
    chk("push5_done", 32'(acc), 32'd1);
    idle(5, 1'b1);
    chk("pop_count", 32'(pop_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < pop_log.size())
        chk("pop_order", 32'(pop_log[i]), 32'(exp_chars[i]));

    // reset while terminal with characters queued
    do_reset();
    for (int i = 0; i < 3; i++)
      wr_reg({REG_CHAR, 2'b00}, 32'h61 + 32'(i), 1'b0);
`ifdef NANORV32_TSTAT_WDOG_EN
    wr_reg({REG_WDOG, 2'b00}, 32'd2, 1'b0);
    idle(3, 1'b0);
    chk("pre_rst_result", 32'(result), 32'd3);
`else
    wr_reg({REG_STATUS, 2'b00}, MAGIC_FAIL, 1'b0);
    chk("pre_rst_result", 32'(result), 32'd1);
`endif
    chk("pre_rst_valid", 32'(char_valid), 32'd1);
    do_reset();

    // random traffic
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        s  = ($urandom_range(0, 9) < 6);
        w  = 1'($urandom_range(0, 1));
        cr = 1'($urandom_range(0, 1));
        k  = $urandom_range(0, 3);
        if (k == 0 && w && $urandom_range(0, 39) != 0) k = 3;
        k2 = k[1:0];
        d  = $urandom;
        if (k2 == REG_WDOG) d = $urandom_range(0, 30);
        if (k2 == REG_STATUS) begin
          case ($urandom_range(0, 2))
            0:       d = MAGIC_PASS;
            1:       d = MAGIC_FAIL;
            default: d = $urandom;
          endcase
        end
        cycle(s, w, {k2, 2'($urandom_range(0, 3))}, d, cr, acc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
